// File: rtl/reg_file_p.sv
// reg_file_p : parameterised operand register file.
//   DEPTH x WIDTH flop storage, one write port, two independent registered
//   read ports with write-to-read bypass, optional hard-wired zero entry,
//   and a DEPTH-cycle clear sequencer.
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   wr/wr_addr/d_in   : write port (rejected while busy)
//   rd_en_x/rd_addr_x : read port x request, d_out_x registered result
//   clr               : start a clear sweep (ignored while sweeping)
//   busy              : sweep in progress
//   wr_drop           : one-cycle pulse after a rejected write

// Per-port read logic: selects zero entry, bypassed write data, bypassed
// clear, or stored contents, and registers the result.
module reg_file_p_rd #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic                        rd_en,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr_acc,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            d_in,
  input  logic                        clr_act,
  input  logic [AW-1:0]               clr_ptr,
  output logic [WIDTH-1:0]            d_out
);
  logic [WIDTH-1:0] d_out_d, d_out_q;

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      if (ZERO_REG != 0 && rd_addr == '0)
        d_out_d = '0;
      else if (wr_acc && rd_addr == wr_addr)
        d_out_d = d_in;
      // the entry being cleared this edge reads as already cleared
      else if (clr_act && rd_addr == clr_ptr)
        d_out_d = '0;
      else
        d_out_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) d_out_q <= '0;
    else       d_out_q <= d_out_d;
  end

  assign d_out = d_out_q;
endmodule

module reg_file_p #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] d_out_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] d_out_b,
  input  logic             clr,
  output logic             busy,
  output logic             wr_drop
);
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                        state_d, state_q;
  logic [AW-1:0]                 ptr_d, ptr_q;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_d, mem_q;
  logic                          wr_drop_d, wr_drop_q;
  logic                          sweep, wr_acc;

  assign sweep = (state_q == SWEEP);
  // writes to the hard-wired zero entry vanish without a drop pulse
  assign wr_acc = wr && !sweep && !(ZERO_REG != 0 && wr_addr == '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) mem_d[wr_addr] = d_in;
    if (sweep)  mem_d[ptr_q]   = '0;
  end

  assign wr_drop_d = wr && sweep;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      mem_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mem_q     <= mem_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  reg_file_p_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd_a (
    .clk(clk), .reset(reset), .mem(mem_q), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .wr_acc(wr_acc), .wr_addr(wr_addr), .d_in(d_in),
    .clr_act(sweep), .clr_ptr(ptr_q), .d_out(d_out_a)
  );

  reg_file_p_rd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd_b (
    .clk(clk), .reset(reset), .mem(mem_q), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .wr_acc(wr_acc), .wr_addr(wr_addr), .d_in(d_in),
    .clr_act(sweep), .clr_ptr(ptr_q), .d_out(d_out_b)
  );

  assign busy    = sweep;
  assign wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_p.sv
module tb_reg_file_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // shared stimulus for the two 8x16 instances (ZERO_REG 0 and 1)
  logic        reset, wr, rd_en_a, rd_en_b, clr;
  logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] d_in;
  logic [15:0] oa0, ob0, oa1, ob1;
  logic        busy0, drop0, busy1, drop1;

  // 32x32 instance
  logic        reset2, wr2, rd_en_a2, rd_en_b2, clr2;
  logic [4:0]  wr_addr2, rd_addr_a2, rd_addr_b2;
  logic [31:0] d_in2, oa2, ob2;
  logic        busy2, drop2;

  reg_file_p #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .d_out_a(oa0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .d_out_b(ob0),
    .clr(clr), .busy(busy0), .wr_drop(drop0));

  reg_file_p #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .d_out_a(oa1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .d_out_b(ob1),
    .clr(clr), .busy(busy1), .wr_drop(drop1));

  reg_file_p #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut2 (
    .clk(clk), .reset(reset2), .wr(wr2), .wr_addr(wr_addr2), .d_in(d_in2),
    .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2), .d_out_a(oa2),
    .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2), .d_out_b(ob2),
    .clr(clr2), .busy(busy2), .wr_drop(drop2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr = 0; wr_addr = 0; d_in = 0; rd_en_a = 0; rd_addr_a = 0;
    rd_en_b = 0; rd_addr_b = 0; clr = 0;
  endtask

  initial begin
    int cnt;
    idle_in();
    reset = 1;
    reset2 = 1; wr2 = 0; wr_addr2 = 0; d_in2 = 0; rd_en_a2 = 0; rd_addr_a2 = 0;
    rd_en_b2 = 0; rd_addr_b2 = 0; clr2 = 0;
    #1;
    step(); step();
    chk("rst_oa", 32'(oa0), 0);
    chk("rst_ob", 32'(ob0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_drop", 32'(drop0), 0);
    reset = 0;

    // all entries zero after reset
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1; rd_en_b = 1; rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      step();
      chk($sformatf("rst_rd_a%0d", i), 32'(oa0), 0);
      chk($sformatf("rst_rd_b%0d", i), 32'(ob0), 0);
    end
    idle_in();

    // basic write then read
    wr = 1; wr_addr = 3; d_in = 16'hA5A5; step();
    wr_addr = 7; d_in = 16'h1234; step();
    idle_in(); rd_en_a = 1; rd_addr_a = 3; rd_en_b = 1; rd_addr_b = 7; step();
    chk("basic_a", 32'(oa0), 32'hA5A5);
    chk("basic_b", 32'(ob0), 32'h1234);

    // bypass on both ports, then hold
    wr = 1; wr_addr = 5; d_in = 16'hBEEF; rd_addr_a = 5; rd_addr_b = 5; step();
    chk("byp_a", 32'(oa0), 32'hBEEF);
    chk("byp_b", 32'(ob0), 32'hBEEF);
    chk("byp_z1_a", 32'(oa1), 32'hBEEF);
    idle_in(); rd_addr_a = 2; rd_addr_b = 3; step();
    chk("hold_a", 32'(oa0), 32'hBEEF);
    chk("hold_b", 32'(ob0), 32'hBEEF);

    // zero register
    wr = 1; wr_addr = 0; d_in = 16'hFFFF; rd_en_a = 1; rd_addr_a = 0; step();
    chk("z1_same", 32'(oa1), 0);
    chk("z1_drop", 32'(drop1), 0);
    chk("z0_byp", 32'(oa0), 32'hFFFF);
    idle_in(); rd_en_a = 1; rd_addr_a = 0; step();
    chk("z1_later", 32'(oa1), 0);
    chk("z0_later", 32'(oa0), 32'hFFFF);
    chk("z1_drop2", 32'(drop1), 0);

    // fill 0x1111*addr, then clear sweep
    idle_in();
    for (int i = 0; i < 8; i++) begin
      wr = 1; wr_addr = 3'(i); d_in = 16'(16'h1111 * i); step();
    end
    idle_in(); clr = 1; step();
    chk("swp_busy0", 32'(busy0), 1);
    for (int k = 1; k <= 8; k++) begin
      idle_in();
      if (k == 1) begin wr = 1; wr_addr = 6; d_in = 16'hDEAD; end
      if (k == 2) clr = 1;
      if (k == 3) begin rd_en_a = 1; rd_addr_a = 7; end
      if (k == 4) begin rd_en_b = 1; rd_addr_b = 3; end
      if (k == 5) begin rd_en_a = 1; rd_addr_a = 6; end
      step();
      chk($sformatf("swp_busy%0d", k), 32'(busy0), (k < 8) ? 1 : 0);
      if (k == 1) chk("swp_drop", 32'(drop0), 1);
      if (k == 2) chk("swp_drop_end", 32'(drop0), 0);
      if (k == 3) chk("swp_rd7", 32'(oa0), 32'h7777);
      if (k == 4) chk("swp_rdptr", 32'(ob0), 0);
      if (k == 5) chk("swp_rd6", 32'(oa0), 32'h6666);
    end
    idle_in(); step();
    chk("swp_noretrig", 32'(busy0), 0);
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1; rd_addr_a = 3'(i); rd_en_b = 1; rd_addr_b = 3'(i);
      step();
      chk($sformatf("clr_a%0d", i), 32'(oa0), 0);
    end

    // reset in the middle of a sweep
    idle_in(); wr = 1; wr_addr = 5; d_in = 16'h5555; rd_en_a = 1; rd_addr_a = 5;
    rd_en_b = 1; rd_addr_b = 5; step();
    chk("pre_rst_a", 32'(oa0), 32'h5555);
    idle_in(); clr = 1; step();
    idle_in(); step(); step(); step();
    chk("mid_busy", 32'(busy0), 1);
    reset = 1; step(); reset = 0;
    chk("mrst_busy", 32'(busy0), 0);
    chk("mrst_oa", 32'(oa0), 0);
    chk("mrst_ob", 32'(ob0), 0);
    wr = 1; wr_addr = 2; d_in = 16'h00FF; step();
    idle_in(); rd_en_a = 1; rd_addr_a = 2; rd_en_b = 1; rd_addr_b = 5; step();
    chk("mrst_rd2", 32'(oa0), 32'h00FF);
    chk("mrst_rd5", 32'(ob0), 0);
    chk("mrst_busy2", 32'(busy0), 0);

    // 32x32: walking ones and a 32-cycle sweep
    step(); reset2 = 0;
    for (int i = 0; i < 32; i++) begin
      wr2 = 1; wr_addr2 = 5'(i); d_in2 = 32'h1 << i; step();
    end
    wr2 = 0;
    for (int i = 0; i < 32; i++) begin
      rd_en_a2 = 1; rd_addr_a2 = 5'(i); rd_en_b2 = 1; rd_addr_b2 = 5'(31 - i);
      step();
      chk($sformatf("w1_a%0d", i), oa2, 32'h1 << i);
      chk($sformatf("w1_b%0d", i), ob2, 32'h1 << (31 - i));
    end
    rd_en_a2 = 0; rd_en_b2 = 0;
    clr2 = 1; step(); clr2 = 0;
    cnt = 0;
    while (busy2 && cnt < 100) begin
      cnt++;
      step();
    end
    chk("sweep32_len", 32'(cnt), 32);
    rd_en_a2 = 1; rd_addr_a2 = 5'd31; rd_en_b2 = 1; rd_addr_b2 = 5'd0; step();
    chk("sweep32_a", oa2, 0);
    chk("sweep32_b", ob2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
